// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP     = 32'h0;
  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_queue.sv
// rtl/if_fetch_unit_queue.sv - prefetch FIFO holding {pc+4, instruction} pairs
// Flush wins over push and pop on the same edge.
module fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            flush_i,
  input  fq_entry_t       data_i,
  output fq_entry_t       head_o,
  output logic [CW-1:0]   count_o
);

  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  fq_entry_t     mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC, single-outstanding imem handshake, prefetch queue
// Branch redirect flushes the queue and drains any in-flight response.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_out,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q;
  logic [31:0]   fetch_pc_q;
  logic [CW-1:0] count;
  logic [CW:0]   count_next;
  fq_entry_t     head;
  fq_entry_t     push_entry;
  logic          push;
  logic          pop;
  logic          issue;

  assign pop  = valid_out & ~freeze & ~branch_taken;
  assign push = imem_rvalid & (state_q == WAIT) & ~branch_taken;
  assign count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

  // rst_n gates the request so the port reads zero throughout reset.
  assign issue = rst_n & ~branch_taken
               & ((state_q == IDLE) | imem_rvalid)
               & (count_next < (CW+1)'(DEPTH));

  // While WAIT, fetch_pc_q already holds the outstanding address + 4.
  assign push_entry = '{pc_plus4: fetch_pc_q, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc_q <= word_align(branch_addr);
      state_q    <= (state_q != IDLE && !imem_rvalid) ? DRAIN : IDLE;
    end else begin
      if (issue) fetch_pc_q <= fetch_pc_q + PC_STEP;
      case (state_q)
        IDLE:        if (issue) state_q <= WAIT;
        WAIT, DRAIN: if (imem_rvalid) state_q <= issue ? WAIT : IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (branch_taken),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_req        = issue;
  assign imem_addr       = issue ? fetch_pc_q : 32'h0;
  assign valid_out       = (count != '0);
  assign PC_out          = valid_out ? head.pc_plus4 : 32'h0;
  assign instruction_out = valid_out ? head.instr : NOP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench with a variable-latency memory model
module tb_if_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;

  if_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .valid_out       (valid_out),
    .PC_out          (PC_out),
    .instruction_out (instruction_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;
  logic [31:0] exp_req;
  int          n_vec = 0;
  int          n_err = 0;
  int          accepts = 0;
  int          lat = 1;
  bit          pend = 0;
  logic [31:0] paddr;
  int          cnt;
  bit          found;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Program order after a reset or redirect: consecutive words from the target.
  task automatic redirect(input logic [31:0] a);
    exp_q.delete();
    next_pc = {a[31:2], 2'b00};
    exp_req = next_pc;
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{next_pc + 32'd4, memf(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic cycle_begin();
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    freeze       = 1'b0;
    if (pend && cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(paddr);
      pend        = 0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (pend) cnt--;
    end
    topup();
  endtask

  task automatic cycle_end();
    @(negedge clk);
    if (rst_n && imem_req === 1'b1) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend  = 1;
      paddr = imem_addr;
      cnt   = lat - 1;
    end
  endtask

  task automatic cyc();
    cycle_begin();
    cycle_end();
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_taken = 1'b1;
    branch_addr  = a;
    redirect(a);
  endtask

  initial begin : monitor
    exp_t        e;
    bit          prev_hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_ins;
    prev_hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_hold = 0;
        continue;
      end
      if (prev_hold) begin
        check("freeze_hold_valid", 32'(valid_out), 32'd1);
        check("freeze_hold_pc", PC_out, hold_pc);
        check("freeze_hold_instr", instruction_out, hold_ins);
      end
      if (valid_out && !freeze && !branch_taken) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty: got pc %h expected no output", PC_out);
        end else begin
          e = exp_q.pop_front();
          check("pc_out", PC_out, e.pc4);
          check("instr_out", instruction_out, e.ins);
          accepts++;
        end
      end else if (!valid_out) begin
        check("empty_pc_zero", PC_out, 32'h0);
        check("empty_nop", instruction_out, 32'h0);
      end
      if (branch_taken) begin
        check("no_req_on_branch", 32'(imem_req), 32'd0);
      end else if (imem_req) begin
        check("req_addr", imem_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      prev_hold = valid_out && freeze && !branch_taken;
      hold_pc   = PC_out;
      hold_ins  = instruction_out;
    end
  end

  initial begin : driver
    rst_n        = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_pc", PC_out, 32'h0);
    check("rst_instr", instruction_out, 32'h0);
    redirect(RESET_PC);

    // Streaming with 1-cycle memory: one instruction per cycle once primed.
    lat = 1;
    cycle_begin();
    rst_n = 1'b1;
    cycle_end();
    for (int i = 1; i < 8; i++) begin
      cyc();
      if (i >= 2) check("stream_valid", 32'(valid_out), 32'd1);
    end

    // Freeze: queue fills to DEPTH then requests stop.
    for (int k = 0; k < 6; k++) begin
      cycle_begin();
      freeze = 1'b1;
      cycle_end();
      if (k >= 3) check("freeze_full_no_req", 32'(imem_req), 32'd0);
    end
    for (int i = 0; i < 6; i++) cyc();

    // Branch while WAIT with 3-cycle memory: stale response drained.
    lat   = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle_begin();
      if (pend) found = 1;
      else cycle_end();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_pending_timeout: got none expected outstanding request");
      cycle_begin();
    end
    do_branch(32'h103);
    cycle_end();
    cyc();
    check("post_branch_empty", 32'(valid_out), 32'd0);
    check("drain_no_req", 32'(imem_req), 32'd0);
    cyc();
    check("drain_reissue", 32'(imem_req), 32'd1);
    for (int i = 0; i < 12; i++) cyc();

    // Branch coinciding with rvalid and freeze: nothing pushed, refetch next cycle.
    lat   = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle_begin();
      if (imem_rvalid) found = 1;
      else cycle_end();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL rvalid_timeout: got none expected a response");
      cycle_begin();
    end
    freeze = 1'b1;
    do_branch(32'h100);
    cycle_end();
    cyc();
    check("branch_rvalid_empty", 32'(valid_out), 32'd0);
    check("branch_idle_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 6; i++) cyc();

    // Address wrap at the top of the 32-bit space.
    cycle_begin();
    do_branch(32'hFFFF_FFF8);
    cycle_end();
    for (int i = 0; i < 8; i++) cyc();

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle_begin();
      lat    = int'($urandom_range(1, 3));
      freeze = ($urandom % 10) < 3;
      if ($urandom % 25 == 0) do_branch($urandom);
      cycle_end();
    end

    // Reset while a 3-cycle request is outstanding; late response lands in IDLE.
    lat   = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle_begin();
      if (pend) found = 1;
      else cycle_end();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL reset_pending_timeout: got none expected outstanding request");
      cycle_begin();
    end
    rst_n = 1'b0;
    #1;
    check("midreset_req", 32'(imem_req), 32'd0);
    check("midreset_addr", imem_addr, 32'h0);
    check("midreset_valid", 32'(valid_out), 32'd0);
    check("midreset_pc", PC_out, 32'h0);
    check("midreset_instr", instruction_out, 32'h0);
    pend = 0;
    redirect(RESET_PC);
    cycle_end();
    cyc();
    lat = 1;
    cycle_begin();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    cycle_end();
    for (int i = 0; i < 12; i++) cyc();

    check("accepts_live", 32'(accepts > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage feeding the IF/ID pipeline register: owns the fetch PC, issues word reads to instruction memory over a request/valid handshake, and buffers returned instructions in a small prefetch queue. Presents one instruction per cycle to the IF stage register, honours hazard freeze from downstream, and redirects on taken branches, discarding in-flight and queued fetches. Sits between instruction memory and the IF stage register.

## Interface
- DEPTH, 2: prefetch queue entries (power of two, ≥2)
- RESET_PC, 32'h0: first fetch address after reset

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- freeze  in  1  downstream hazard stall; hold current output, no pop
- branch_taken  in  1  single-cycle redirect pulse from EXE
- branch_addr  in  32  redirect target; bits [1:0] ignored (forced 0)
- imem_req  out  1  read request, one-cycle pulse per fetch
- imem_addr  out  32  word-aligned fetch address, valid while imem_req=1
- imem_rvalid  in  1  read data valid (≥1 cycle after request)
- imem_rdata  in  32  instruction word, valid with imem_rvalid
- valid_out  out  1  queue head holds an instruction
- PC_out  out  32  fetch address + 4 of head instruction
- instruction_out  out  32  head instruction; 32'h0 (NOP) when empty

## Operation
- Reset (rst_n=0, immediate): fetch_pc=RESET_PC, queue empty, state IDLE, imem_req=0, imem_addr=0, valid_out=0, PC_out=0, instruction_out=0.
- At most one outstanding memory request.
- States: IDLE (nothing outstanding), WAIT (request outstanding, response kept), DRAIN (request outstanding, response to be discarded).
- pop = valid_out & ~freeze & ~branch_taken; push = imem_rvalid & state==WAIT & ~branch_taken; count_next = count + push − pop.
- Issue (imem_req=1, imem_addr=fetch_pc, fetch_pc += 4) when: ~branch_taken, and (state==IDLE or (state∈{WAIT,DRAIN} and imem_rvalid)), and count_next < DEPTH. Issue → WAIT.
- IDLE: issue, else stay. WAIT: rvalid → push {addr+4, rdata}; then issue-or-IDLE. DRAIN: rvalid → data dropped; issue-or-IDLE.
- branch_taken (priority over freeze and push): queue flushed same edge, fetch_pc ← {branch_addr[31:2],2'b00}, no issue that cycle. State: WAIT/DRAIN without rvalid → DRAIN; otherwise → IDLE. First post-branch fetch issues next cycle (from IDLE) or on the drained response.
- Outputs combinational from queue head; valid_out = count≠0.
- Arithmetic: 32-bit, fetch_pc wraps 32'hFFFF_FFFC → 0; PC_out = fetch address + 4 mod 2^32.
- imem_rvalid in IDLE: protocol error, ignored.

## Timing
- 1-cycle memory (rvalid cycle after req): reset release at edge 0 → req addr RESET_PC in cycle 0, push at edge 1, valid_out=1 in cycle 1 with PC_out=RESET_PC+4.
- Steady state with freeze=0 and 1-cycle memory: one instruction per cycle, PC_out advancing by 4.
- freeze=1: head stable; fetching continues until count_next=DEPTH, then imem_req stays low.
- Branch edge: valid_out=0 in next cycle; target instruction visible ≥2 cycles after branch (1-cycle memory, IDLE case).
- Reset mid-request: state cleared immediately; any later rvalid arrives in IDLE and is ignored.

## Structure
- Shared package if_pkg: state enum (IDLE, WAIT, DRAIN), NOP constant 32'h0, PC_STEP = 4, queue entry typedef {pc_plus4[31:0], instr[31:0]}.
- One sub-module: fetch_queue (DEPTH-entry FIFO with push, pop, flush, count, head outputs; async active-low reset).
- FSM, PC register, issue logic in if_fetch_unit.

## Test plan
- Reset then 1-cycle memory, freeze=0: req addrs 0,4,8,…; PC_out 4,8,12,… with instruction_out = memory words, one per cycle from cycle 1.
- freeze=1 for 5 cycles, DEPTH=2: head unchanged, exactly 2 queued, imem_req low after fill; release → next two in order, no loss/dup.
- branch_taken with branch_addr=32'h103 while WAIT, rvalid 2 cycles later: response discarded, next req addr 32'h100, next PC_out 32'h104.
- branch_taken same cycle as imem_rvalid and freeze=1: no push, queue empty next cycle, IDLE, req 0x100 following cycle.
- Start at RESET_PC=32'hFFFF_FFF8: addrs FFFF_FFF8, FFFF_FFFC, 0; PC_out FFFF_FFFC, 0, 4.
- Assert rst_n=0 while WAIT with 3-cycle memory: outputs zero immediately; late rvalid after release ignored; fetch restarts at RESET_PC.
